// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, FSM encoding and S-box tables for the round datapath
// Contents: aes_state_t (128-bit state), aes_word_t (32-bit column),
//           sb_state_e (SubBytes FSM), SBOX / INV_SBOX (256 x 8 lookup tables)
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_word_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} sb_state_e;

   // Element 0 sits in the leftmost (most significant) position of each literal
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward/inverse S-box lookup
// Ports: x (byte in), inv (1 = inverse table), y (substituted byte)
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] x,
   input  logic       inv,
   output logic [7:0] y
);

   assign y = inv ? INV_SBOX[x] : SBOX[x];

endmodule

// File: rtl/subbytes_serial.sv
// subbytes_serial: iterative SubBytes/InvSubBytes, LANES bytes per clock, valid/ready in and out
// Ports: clk, i_reset (sync, active-low), i_enc_or_dec (0 enc / 1 dec, sampled on accept),
//        i_in_valid/o_in_ready/i_in_data (state in), o_out_valid/i_out_ready/o_out_data (state out),
//        o_out_mode (direction travelling with the data), o_busy (substitution in progress)
module subbytes_serial
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic       clk,
   input  logic       i_reset,
   input  logic       i_enc_or_dec,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   input  aes_state_t i_in_data,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output aes_state_t o_out_data,
   output logic       o_out_mode,
   output logic       o_busy
);

   localparam int NPASS = 16 / LANES;
   localparam int CW = NPASS > 1 ? $clog2(NPASS) : 1;

   if (LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("subbytes_serial: LANES must be 4, 8 or 16");
   end

   sb_state_e           state;
   logic [CW-1:0]       cnt;
   aes_state_t          data_q, nxt;
   logic                mode_q, last;
   logic [6:0]          base;
   logic [8*LANES-1:0]  slice, sub;

   // Slices are taken MSB-first: pass k covers bytes starting at bit 127 - 8*LANES*k
   assign base  = 7'(127 - 8 * LANES * int'(cnt));
   assign slice = data_q[base -: 8*LANES];
   assign last  = cnt == CW'(NPASS - 1);

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      aes_sbox u_sbox (.x(slice[8*j +: 8]), .inv(mode_q), .y(sub[8*j +: 8]));
   end

   always_comb begin
      nxt = data_q;
      nxt[base -: 8*LANES] = sub;
   end

   assign o_in_ready = state == IDLE && i_reset;
   assign o_busy     = state == BUSY;

   // Output data/mode are separate registers so partial substitutions never reach the port
   always_ff @(posedge clk) begin
      if (!i_reset) begin
         state       <= IDLE;
         cnt         <= '0;
         data_q      <= '0;
         mode_q      <= 1'b0;
         o_out_valid <= 1'b0;
         o_out_data  <= '0;
         o_out_mode  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_in_valid) begin
               data_q <= i_in_data;
               mode_q <= i_enc_or_dec;
               cnt    <= '0;
               state  <= BUSY;
            end
            BUSY: begin
               data_q <= nxt;
               cnt    <= last ? '0 : cnt + 1'b1;
               if (last) begin
                  state       <= DONE;
                  o_out_valid <= 1'b1;
                  o_out_data  <= nxt;
                  o_out_mode  <= mode_q;
               end
            end
            DONE: if (i_out_ready) begin
               o_out_valid <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_subbytes_serial.sv
// tb_subbytes_serial: self-checking bench for subbytes_serial at LANES = 4, 8 and 16
module tb_subbytes_serial;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         mode      [3];
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_data   [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_data  [3];
   logic         out_mode  [3];
   logic         busy      [3];

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] fwd [256];
   logic [7:0] invt[256];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      subbytes_serial #(.LANES(4 << g)) dut (
         .clk(clk),
         .i_reset(rst),
         .i_enc_or_dec(mode[g]),
         .i_in_valid(in_valid[g]),
         .o_in_ready(in_ready[g]),
         .i_in_data(in_data[g]),
         .o_out_valid(out_valid[g]),
         .i_out_ready(out_ready[g]),
         .o_out_data(out_data[g]),
         .o_out_mode(out_mode[g]),
         .o_busy(busy[g])
      );
   end

   typedef struct {
      logic [127:0] din;
      logic         m;
      logic [127:0] exp;
   } vec_t;

   vec_t tbl[4];

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic hi;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         hi = a[7];
         a = {a[6:0], 1'b0};
         if (hi) a ^= 8'h1b;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(logic [7:0] v, int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map
   task automatic build_model();
      logic [7:0] y, s;
      for (int x = 0; x < 256; x++) begin
         y = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
         s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
         fwd[x] = s;
         invt[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_state(logic [127:0] d, logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? invt[d[8*i +: 8]] : fwd[d[8*i +: 8]];
      return r;
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(int d, logic [127:0] v, logic m);
      int t = 0;
      while (!in_ready[d] && t < 50) begin
         tick();
         t++;
      end
      chk($sformatf("in_ready[%0d] before send", d), 128'(in_ready[d]), 128'd1);
      in_valid[d] = 1'b1;
      in_data[d]  = v;
      mode[d]     = m;
      tick();
      in_valid[d] = 1'b0;
      in_data[d]  = $urandom;
   endtask

   // Counts edges after acceptance until out_valid; the live mode is scrambled meanwhile
   task automatic wait_out(int d, output int lat);
      lat = 0;
      while (!out_valid[d] && lat < 50) begin
         mode[d] = ~mode[d];
         in_valid[d] = $urandom_range(0, 1);
         tick();
         lat++;
      end
      in_valid[d] = 1'b0;
   endtask

   task automatic take(int d);
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
   endtask

   initial begin
      int lat;
      logic [127:0] v;
      logic m;

      for (int d = 0; d < 3; d++) begin
         mode[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
      end
      build_model();

      tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
      tbl[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
      tbl[2] = '{128'h0, 1'b1, {16{8'h52}}};
      tbl[3] = '{{16{8'h53}}, 1'b0, {16{8'hed}}};

      in_valid[0] = 1'b1;
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset out_valid[%0d]", d), 128'(out_valid[d]), 128'd0);
         chk($sformatf("reset out_data[%0d]", d), out_data[d], 128'd0);
         chk($sformatf("reset out_mode[%0d]", d), 128'(out_mode[d]), 128'd0);
         chk($sformatf("reset busy[%0d]", d), 128'(busy[d]), 128'd0);
         chk($sformatf("in_ready in reset[%0d]", d), 128'(in_ready[d]), 128'd0);
      end
      in_valid[0] = 1'b0;
      rst = 1'b1;
      #1;
      chk("in_ready after reset", 128'(in_ready[0]), 128'd1);

      for (int i = 0; i < 4; i++) begin
         send(0, tbl[i].din, tbl[i].m);
         chk($sformatf("vec%0d busy", i), 128'(busy[0]), 128'd1);
         chk($sformatf("vec%0d in_ready busy", i), 128'(in_ready[0]), 128'd0);
         wait_out(0, lat);
         chk($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
         chk($sformatf("vec%0d data", i), out_data[0], tbl[i].exp);
         chk($sformatf("vec%0d mode", i), 128'(out_mode[0]), 128'(tbl[i].m));
         take(0);
      end

      send(0, 128'h0, 1'b0);
      wait_out(0, lat);
      for (int c = 0; c < 10; c++) begin
         mode[0] = ~mode[0];
         chk("bp data", out_data[0], {16{8'h63}});
         chk("bp valid", 128'(out_valid[0]), 128'd1);
         chk("bp in_ready", 128'(in_ready[0]), 128'd0);
         tick();
      end
      take(0);
      chk("bp release in_ready", 128'(in_ready[0]), 128'd1);
      chk("bp release valid", 128'(out_valid[0]), 128'd0);
      chk("bp release busy", 128'(busy[0]), 128'd0);

      send(0, tbl[1].din, 1'b1);
      wait_out(0, lat);
      take(0);
      send(0, tbl[1].din, 1'b1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("rst mid out_valid", 128'(out_valid[0]), 128'd0);
      chk("rst mid out_data", out_data[0], 128'd0);
      chk("rst mid out_mode", 128'(out_mode[0]), 128'd0);
      chk("rst mid busy", 128'(busy[0]), 128'd0);
      chk("rst mid in_ready", 128'(in_ready[0]), 128'd1);
      for (int c = 0; c < 6; c++) begin
         chk("rst no output", 128'(out_valid[0]), 128'd0);
         tick();
      end
      send(0, tbl[0].din, tbl[0].m);
      wait_out(0, lat);
      chk("post-rst latency", 128'(lat), 128'd4);
      chk("post-rst data", out_data[0], tbl[0].exp);
      take(0);

      for (int d = 1; d < 3; d++) begin
         send(d, tbl[0].din, tbl[0].m);
         wait_out(d, lat);
         chk($sformatf("lanes%0d latency", 4 << d), 128'(lat), 128'(4 >> d));
         chk($sformatf("lanes%0d data", 4 << d), out_data[d], tbl[0].exp);
         chk($sformatf("lanes%0d mode", 4 << d), 128'(out_mode[d]), 128'd0);
         take(d);
      end

      for (int d = 0; d < 3; d++) begin
         out_ready[d] = 1'b1;
         for (int i = 0; i < 100; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            send(d, v, m);
            wait_out(d, lat);
            chk($sformatf("stream%0d data", d), out_data[d], ref_state(v, m));
            chk($sformatf("stream%0d mode", d), 128'(out_mode[d]), 128'(m));
         end
         out_ready[d] = 1'b0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
      $fatal(1);
   end

endmodule
